// File: rtl/leak_monitor_pkg.sv
// Shared types and defaults for the leak monitor: FSM state encoding and
// default counter width / measurement timeout.
package leak_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } monitorStateT;

  localparam int DEFAULT_CNT_WIDTH = 16;
  localparam int DEFAULT_TIMEOUT   = 1024;

endpackage

// File: rtl/leak_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // Holds at all-ones once reached instead of wrapping back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/leak_monitor.sv
// Timing-leak monitor: measures completion latency of two multiplier copies
// started together and flags a mismatch. Macro LEAK_MONITOR_MAX_DELTA_EN adds max_delta.
module leak_monitor
  import leak_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 done_one,
  input  logic                 done_two,
  input  logic                 clear_stats,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 leak,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] lat_one,
  output logic [CNT_WIDTH-1:0] lat_two,
  output logic [CNT_WIDTH-1:0] delta,
  output logic [CNT_WIDTH-1:0] trial_count,
  output logic [CNT_WIDTH-1:0] leak_count
`ifdef LEAK_MONITOR_MAX_DELTA_EN
  , output logic [CNT_WIDTH-1:0] max_delta
`endif
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  monitorStateT state, nextState;

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] latOne, latTwo;
  logic                 seenOne, seenTwo;
  logic                 timeoutFlag;
  logic                 seenNowOne, seenNowTwo, bothSeen, expire;
  logic                 leakNow;
  logic [CNT_WIDTH-1:0] deltaVal;

  assign seenNowOne = seenOne | done_one;
  assign seenNowTwo = seenTwo | done_two;
  assign bothSeen   = seenNowOne & seenNowTwo;
  assign expire     = (cnt == TIMEOUT_CNT) && !bothSeen;
  assign leakNow    = (latOne != latTwo) | timeoutFlag;
  assign deltaVal   = (latOne >= latTwo) ? (latOne - latTwo) : (latTwo - latOne);

  // Held at zero while idle so that accepting start lands it exactly on 1.
  sat_counter #(.WIDTH(CNT_WIDTH)) cycleCounter (
    .clk (clk),
    .rst (rst),
    .clr ((state == IDLE) && !start),
    .inc (((state == IDLE) && start) || (state == MEASURE)),
    .q   (cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) trialCounter (
    .clk (clk),
    .rst (rst),
    .clr (clear_stats),
    .inc (state == REPORT),
    .q   (trial_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) leakCounter (
    .clk (clk),
    .rst (rst),
    .clr (clear_stats),
    .inc ((state == REPORT) && leakNow),
    .q   (leak_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = MEASURE;
      MEASURE: if (bothSeen || expire) nextState = REPORT;
      REPORT:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      MEASURE: busy = 1'b1;
      REPORT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Only the first done of each copy is latched; on expiry any copy still
  // unseen reports an all-ones latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latOne      <= '0;
      latTwo      <= '0;
      seenOne     <= 1'b0;
      seenTwo     <= 1'b0;
      timeoutFlag <= 1'b0;
    end else if ((state == IDLE) && start) begin
      latOne      <= '0;
      latTwo      <= '0;
      seenOne     <= 1'b0;
      seenTwo     <= 1'b0;
      timeoutFlag <= 1'b0;
    end else if (state == MEASURE) begin
      if (done_one && !seenOne) begin
        latOne  <= cnt;
        seenOne <= 1'b1;
      end
      if (done_two && !seenTwo) begin
        latTwo  <= cnt;
        seenTwo <= 1'b1;
      end
      if (expire) begin
        timeoutFlag <= 1'b1;
        if (!seenNowOne) latOne <= '1;
        if (!seenNowTwo) latTwo <= '1;
      end
    end
  end

  assign lat_one = latOne;
  assign lat_two = latTwo;
  assign delta   = deltaVal;
  assign leak    = leakNow;
  assign timeout = timeoutFlag;

`ifdef LEAK_MONITOR_MAX_DELTA_EN
  logic [CNT_WIDTH-1:0] maxDelta;

  // Timed-out trials carry a synthetic all-ones latency, so they are excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maxDelta <= '0;
    end else if (clear_stats) begin
      maxDelta <= '0;
    end else if ((state == REPORT) && !timeoutFlag && (deltaVal > maxDelta)) begin
      maxDelta <= deltaVal;
    end
  end

  assign max_delta = maxDelta;
`endif

endmodule

// File: tb/tb_leak_monitor.sv
// Scoreboard testbench for leak_monitor: directed trials push expected verdicts,
// a monitor process checks each REPORT and the statistics that follow it.
module tb_leak_monitor;

  localparam int W  = 16;
  localparam int TO = 100;

  typedef struct {
    logic [W-1:0] latOne;
    logic [W-1:0] latTwo;
    logic [W-1:0] delta;
    logic         leak;
    logic         timeout;
    logic [W-1:0] trialCnt;
    logic [W-1:0] leakCnt;
    logic [W-1:0] maxDelta;
  } expT;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done_one;
  logic         done_two;
  logic         clear_stats;
  logic         busy;
  logic         result_valid;
  logic         leak;
  logic         timeout;
  logic [W-1:0] lat_one;
  logic [W-1:0] lat_two;
  logic [W-1:0] delta;
  logic [W-1:0] trial_count;
  logic [W-1:0] leak_count;
`ifdef LEAK_MONITOR_MAX_DELTA_EN
  logic [W-1:0] max_delta;
`endif

  expT          sbQueue[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] expTrial = '0;
  logic [W-1:0] expLeak  = '0;
  logic [W-1:0] expMax   = '0;

  leak_monitor #(.CNT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done_one     (done_one),
    .done_two     (done_two),
    .clear_stats  (clear_stats),
    .busy         (busy),
    .result_valid (result_valid),
    .leak         (leak),
    .timeout      (timeout),
    .lat_one      (lat_one),
    .lat_two      (lat_two),
    .delta        (delta),
    .trial_count  (trial_count),
    .leak_count   (leak_count)
`ifdef LEAK_MONITOR_MAX_DELTA_EN
    , .max_delta  (max_delta)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One trial: d1/d2 are the MEASURE cycles of each done (0 = never), dupOne a
  // later repeat of done_one, rptClear/rptStart are driven during REPORT.
  task automatic applyStimulus(input int d1, input int d2, input int dupOne,
                               input bit rptClear, input bit rptStart);
    int           endCycle;
    bit           eTo;
    logic [W-1:0] eOne, eTwo;
    expT          e;
    eTo      = !(d1 > 0 && d2 > 0 && d1 <= TO && d2 <= TO);
    endCycle = eTo ? TO : ((d1 > d2) ? d1 : d2);
    eOne     = (d1 > 0 && d1 <= endCycle) ? W'(d1) : {W{1'b1}};
    eTwo     = (d2 > 0 && d2 <= endCycle) ? W'(d2) : {W{1'b1}};
    e.latOne  = eOne;
    e.latTwo  = eTwo;
    e.delta   = (eOne >= eTwo) ? (eOne - eTwo) : (eTwo - eOne);
    e.leak    = (eOne != eTwo) || eTo;
    e.timeout = eTo;
    if (rptClear) begin
      expTrial = '0;
      expLeak  = '0;
      expMax   = '0;
    end else begin
      expTrial = expTrial + 1'b1;
      if (e.leak) expLeak = expLeak + 1'b1;
      if (!eTo && e.delta > expMax) expMax = e.delta;
    end
    e.trialCnt = expTrial;
    e.leakCnt  = expLeak;
    e.maxDelta = expMax;
    sbQueue.push_back(e);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= endCycle; c++) begin
      done_one = (c == d1) || (c == dupOne);
      done_two = (c == d2);
      @(posedge clk); #1;
    end
    done_one    = 1'b0;
    done_two    = 1'b0;
    clear_stats = rptClear;
    start       = rptStart;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    start       = 1'b0;
    if (rptStart) checkOutput("startInReportIgnored", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: verdict checked in the REPORT cycle, statistics one cycle later.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedReport: got result_valid 1 expected 0");
        end else begin
          e = sbQueue.pop_front();
          checkOutput("latOne",  32'(lat_one), 32'(e.latOne));
          checkOutput("latTwo",  32'(lat_two), 32'(e.latTwo));
          checkOutput("delta",   32'(delta),   32'(e.delta));
          checkOutput("leak",    32'(leak),    32'(e.leak));
          checkOutput("timeout", 32'(timeout), 32'(e.timeout));
          @(negedge clk);
          checkOutput("trialCount", 32'(trial_count), 32'(e.trialCnt));
          checkOutput("leakCount",  32'(leak_count),  32'(e.leakCnt));
`ifdef LEAK_MONITOR_MAX_DELTA_EN
          checkOutput("maxDelta",   32'(max_delta),   32'(e.maxDelta));
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; done_one = 1'b0; done_two = 1'b0; clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy",       32'(busy),         32'd0);
    checkOutput("resetValid",      32'(result_valid), 32'd0);
    checkOutput("resetTrialCount", 32'(trial_count),  32'd0);
    checkOutput("resetLeakCount",  32'(leak_count),   32'd0);
    checkOutput("resetLatOne",     32'(lat_one),      32'd0);
    checkOutput("resetDelta",      32'(delta),        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] done inputs while idle");
    done_one = 1'b1; done_two = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("doneInIdleIgnored", 32'(busy), 32'd0);
    done_one = 1'b0; done_two = 1'b0;
    @(posedge clk); #1;

    $display("[TB] matched, mismatched, repeat-done and timeout trials");
    applyStimulus(70, 70, 0, 1'b0, 1'b0);
    applyStimulus(66, 70, 0, 1'b0, 1'b0);
    applyStimulus(1, 3, 0, 1'b0, 1'b0);
    applyStimulus(4, 6, 5, 1'b0, 1'b0);
    applyStimulus(10, 0, 0, 1'b0, 1'b0);

    $display("[TB] clear_stats and start during REPORT");
    applyStimulus(3, 8, 0, 1'b1, 1'b1);
    applyStimulus(5, 5, 0, 1'b0, 1'b0);

    $display("[TB] reset in MEASURE cycle 30");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      done_one = (c == 20);
      @(posedge clk); #1;
    end
    done_one = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("midResetBusy",       32'(busy),        32'd0);
    checkOutput("midResetLatOne",     32'(lat_one),     32'd0);
    checkOutput("midResetTrialCount", 32'(trial_count), 32'd0);
    rst = 1'b0;
    expTrial = '0;
    expLeak  = '0;
    expMax   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleAfterReset", 32'(busy), 32'd0);
    applyStimulus(2, 7, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leak_monitor.md
LEAK_MONITOR -- requirements
Module: leak_monitor

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of all latency and statistics counters.
REQ-002 Parameter TIMEOUT, default 1024, maximum MEASURE cycles before forced report; SHALL be in 2..2^CNT_WIDTH-2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  trial start, the same pulse driven to both multiplier copies.
REQ-006 done_one, done_two  input  1 each  productDone of copy one / copy two.
REQ-007 clear_stats  input  1  synchronous clear of trial_count and leak_count.
REQ-008 busy  output  1  high in MEASURE and REPORT.
REQ-009 result_valid  output  1  one-cycle pulse in REPORT.
REQ-010 leak, timeout  output  1 each  trial verdict; meaningful only while result_valid is high.
REQ-011 lat_one, lat_two, delta  output  CNT_WIDTH each  measured latencies and their absolute difference.
REQ-012 trial_count, leak_count  output  CNT_WIDTH each  running statistics.

Function
REQ-013 FSM states SHALL be IDLE, MEASURE and REPORT.
REQ-014 IDLE->MEASURE SHALL occur on start=1, which clears cycle counter cnt to 1, sticky flags seen_one and seen_two, and lat_one and lat_two.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 done inputs SHALL be ignored in IDLE and REPORT.
REQ-017 In MEASURE, cnt SHALL increment each cycle, saturating at all-ones.
REQ-018 On the first MEASURE cycle with done_x=1, lat_x SHALL latch cnt and seen_x SHALL set; later done_x pulses SHALL not alter lat_x.
REQ-019 MEASURE->REPORT SHALL occur in the cycle both flags are set, counting flags set in the current cycle; simultaneous dones SHALL latch equal values.
REQ-020 MEASURE->REPORT SHALL also occur when cnt==TIMEOUT with a flag still clear: timeout=1 and each unseen lat_x reads all-ones.
REQ-021 REPORT SHALL last exactly one cycle with result_valid=1, then return to IDLE.
REQ-022 In REPORT, leak=(lat_one!=lat_two)|timeout, and delta=|lat_one-lat_two| computed unsigned without wrap.
REQ-023 trial_count SHALL increment in REPORT, saturating at all-ones.
REQ-024 leak_count SHALL increment in REPORT when leak=1, saturating at all-ones.
REQ-025 clear_stats=1 SHALL zero both counts in any state and SHALL win over a coincident REPORT increment.
REQ-026 lat_one, lat_two and delta SHALL hold their values until the next start is accepted.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, including mid-MEASURE, and all outputs, counters and flags to 0, with no REPORT emitted.
REQ-028 After rst deasserts, the first accepted start SHALL be no earlier than the following clock edge.

Configuration
REQ-029 Macro LEAK_MONITOR_MAX_DELTA_EN defined: add output max_delta [CNT_WIDTH], updated in REPORT to max(max_delta, delta) for non-timeout trials, cleared by rst and clear_stats.
REQ-030 LEAK_MONITOR_MAX_DELTA_EN undefined: no max_delta port and no associated logic.

Structure
REQ-031 Package leak_monitor_pkg SHALL hold the FSM state encoding (IDLE=2'd0, MEASURE=2'd1, REPORT=2'd2) and the default CNT_WIDTH and TIMEOUT constants.
REQ-032 Sub-module sat_counter (parameter WIDTH; ports clr, inc, q; saturating increment) SHALL implement cnt, trial_count and leak_count.

Verification
REQ-033 Matched: start; done_one and done_two both at MEASURE cycle 70 -> lat_one=lat_two=70, delta=0, leak=0, trial_count=1, leak_count=0.
REQ-034 Mismatch: done_one at cycle 66, done_two at cycle 70 -> lat_one=66, lat_two=70, delta=4, leak=1, leak_count=1.
REQ-035 Timeout, TIMEOUT=100: done_one at 10, no done_two -> result_valid at cycle 100 REPORT, timeout=1, lat_one=10, lat_two=16'hFFFF, leak=1.
REQ-036 rst pulsed in MEASURE cycle 30 -> IDLE, no result_valid, counts 0; a new start measures from cnt=1.
REQ-037 clear_stats coincident with a leaky REPORT -> trial_count=0, leak_count=0; a start during REPORT is ignored.
REQ-038 With macro defined, deltas 4 then 2 -> max_delta=4; clear_stats -> max_delta=0.
